// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO: first-word-fall-through read, occupancy count,
// almost-full/almost-empty watermarks, synchronous flush and sticky error flags.
module param_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  clear,
  input  logic                  w_enable,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_enable,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [AW:0]           count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [AW:0] AF_C  = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_C  = (AW+1)'(AE_THRESH);
  localparam logic [AW:0] ONE_C = (AW+1)'(1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]           w_ptr_r;
  logic [AW:0]           r_ptr_r;
  logic [AW:0]           count_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  w_ena_s;
  logic                  r_ena_s;
  logic [DATA_WIDTH-1:0] r_data_s;

  // Full/empty come from the pointers; the extra wrap bit separates the two cases.
  always_comb begin
    full_s  = (w_ptr_r[AW-1:0] == r_ptr_r[AW-1:0]) && (w_ptr_r[AW] != r_ptr_r[AW]);
    empty_s = (w_ptr_r == r_ptr_r);
  end

  // Accepted requests; a flush in the same cycle drops both.
  always_comb begin
    w_ena_s = w_enable & ~full_s & ~clear;
    r_ena_s = r_enable & ~empty_s & ~clear;
  end

  // Head entry is presented directly; zero while nothing is stored.
  always_comb begin
    if (empty_s) begin
      r_data_s = {DATA_WIDTH{1'b0}};
    end else begin
      r_data_s = mem_r[r_ptr_r[AW-1:0]];
    end
  end

  // Storage array, intentionally without reset.
  always_ff @(posedge clk) begin
    if (w_ena_s) begin
      mem_r[w_ptr_r[AW-1:0]] <= w_data;
    end
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      w_ptr_r     <= '0;
      r_ptr_r     <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (clear) begin
      w_ptr_r     <= '0;
      r_ptr_r     <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (w_ena_s) begin
        w_ptr_r <= w_ptr_r + ONE_C;
      end
      if (r_ena_s) begin
        r_ptr_r <= r_ptr_r + ONE_C;
      end
      case ({w_ena_s, r_ena_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
      if (w_enable && full_s) begin
        overflow_r <= 1'b1;
      end
      if (r_enable && empty_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign r_data       = r_data_s;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_r >= AF_C);
  assign almost_empty = (count_r <= AE_C);
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo: default 8x8 instance plus a 16-bit x 4 sweep instance.
module tb_param_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_rst_a = 1'b0, clear_a = 1'b0, w_en_a = 1'b0, r_en_a = 1'b0;
  logic [7:0] w_data_a = 8'h00, r_data_a;
  logic       full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
  logic [3:0] count_a;

  logic        n_rst_b = 1'b0, clear_b = 1'b0, w_en_b = 1'b0, r_en_b = 1'b0;
  logic [15:0] w_data_b = 16'h0000, r_data_b;
  logic        full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
  logic [2:0]  count_b;

  int total = 0;
  int bad   = 0;

  param_fifo dut_a (
    .clk(clk), .n_rst(n_rst_a), .clear(clear_a), .w_enable(w_en_a), .w_data(w_data_a),
    .r_enable(r_en_a), .r_data(r_data_a), .full(full_a), .empty(empty_a),
    .almost_full(af_a), .almost_empty(ae_a), .count(count_a),
    .overflow(ovf_a), .underflow(unf_a)
  );

  param_fifo #(.DATA_WIDTH(16), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(0)) dut_b (
    .clk(clk), .n_rst(n_rst_b), .clear(clear_b), .w_enable(w_en_b), .w_data(w_data_b),
    .r_enable(r_en_b), .r_data(r_data_b), .full(full_b), .empty(empty_b),
    .almost_full(af_b), .almost_empty(ae_b), .count(count_b),
    .overflow(ovf_b), .underflow(unf_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] d);
    w_en_a = 1'b1; w_data_a = d; step(); w_en_a = 1'b0;
  endtask

  task automatic pop_a();
    r_en_a = 1'b1; step(); r_en_a = 1'b0;
  endtask

  task automatic both_a(input logic [7:0] d);
    w_en_a = 1'b1; r_en_a = 1'b1; w_data_a = d; step();
    w_en_a = 1'b0; r_en_a = 1'b0;
  endtask

  task automatic flush_a();
    clear_a = 1'b1; step(); clear_a = 1'b0;
  endtask

  task automatic push_b(input logic [15:0] d);
    w_en_b = 1'b1; w_data_b = d; step(); w_en_b = 1'b0;
  endtask

  task automatic pop_b();
    r_en_b = 1'b1; step(); r_en_b = 1'b0;
  endtask

  task automatic test_reset();
    n_rst_a = 1'b0; n_rst_b = 1'b0;
    #2;
    total++; if (count_a !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_a); end
    total++; if ({empty_a, full_a, ae_a, af_a, ovf_a, unf_a} !== 6'b101000) begin
      bad++; $display("FAIL reset_flags got=%b exp=101000", {empty_a, full_a, ae_a, af_a, ovf_a, unf_a}); end
    total++; if (r_data_a !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h exp=00", r_data_a); end
    total++; if ({empty_b, full_b, ae_b, af_b, count_b} !== 7'b1010000) begin
      bad++; $display("FAIL reset_b got=%b exp=1010000", {empty_b, full_b, ae_b, af_b, count_b}); end
    @(negedge clk);
    n_rst_a = 1'b1; n_rst_b = 1'b1;
    step();
    total++; if ({empty_a, unf_a, count_a} !== 6'b100000) begin
      bad++; $display("FAIL idle got=%b exp=100000", {empty_a, unf_a, count_a}); end
    pop_a();
    total++; if ({empty_a, unf_a, count_a} !== 6'b110000) begin
      bad++; $display("FAIL underflow_idle got=%b exp=110000", {empty_a, unf_a, count_a}); end
  endtask

  task automatic test_fill();
    flush_a();
    total++; if ({ovf_a, unf_a} !== 2'b00) begin bad++; $display("FAIL clear_flags got=%b exp=00", {ovf_a, unf_a}); end
    for (int i = 1; i <= 8; i++) begin
      push_a(8'(i));
      total++; if (count_a !== 4'(i)) begin bad++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count_a, i); end
      total++; if ({af_a, ae_a, full_a} !== {(i >= 7), (i <= 1), (i == 8)}) begin
        bad++; $display("FAIL fill_flags i=%0d got=%b exp=%b", i, {af_a, ae_a, full_a}, {(i >= 7), (i <= 1), (i == 8)}); end
    end
    push_a(8'hFF);
    total++; if ({ovf_a, full_a, count_a} !== 6'b111000) begin
      bad++; $display("FAIL overflow got=%b exp=111000", {ovf_a, full_a, count_a}); end
    for (int i = 1; i <= 8; i++) begin
      total++; if (r_data_a !== 8'(i)) begin bad++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, r_data_a, 8'(i)); end
      pop_a();
    end
    total++; if ({empty_a, count_a, r_data_a} !== {1'b1, 4'd0, 8'h00}) begin
      bad++; $display("FAIL drain_end got=%b/%0d/%h exp=1/0/00", empty_a, count_a, r_data_a); end
  endtask

  task automatic test_wrap();
    flush_a();
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 5; j++) push_a(8'(r * 16 + j + 1));
      total++; if (count_a !== 4'd5) begin bad++; $display("FAIL wrap_count r=%0d got=%0d exp=5", r, count_a); end
      for (int j = 0; j < 5; j++) begin
        total++; if (r_data_a !== 8'(r * 16 + j + 1)) begin
          bad++; $display("FAIL wrap_data r=%0d j=%0d got=%h exp=%h", r, j, r_data_a, 8'(r * 16 + j + 1)); end
        pop_a();
      end
    end
    total++; if ({empty_a, full_a, count_a} !== 6'b100000) begin
      bad++; $display("FAIL wrap_end got=%b exp=100000", {empty_a, full_a, count_a}); end
  endtask

  task automatic test_back_to_back();
    flush_a();
    push_a(8'h10); push_a(8'h11); push_a(8'h12);
    both_a(8'h13);
    total++; if ({count_a, r_data_a} !== {4'd3, 8'h11}) begin
      bad++; $display("FAIL simul_mid got=%0d/%h exp=3/11", count_a, r_data_a); end
    flush_a();
    for (int i = 0; i < 8; i++) push_a(8'(8'h20 + i));
    both_a(8'h99);
    total++; if ({count_a, ovf_a, full_a, r_data_a} !== {4'd7, 1'b1, 1'b0, 8'h21}) begin
      bad++; $display("FAIL simul_full got=%0d/%b/%b/%h exp=7/1/0/21", count_a, ovf_a, full_a, r_data_a); end
    flush_a();
    both_a(8'hA5);
    total++; if ({count_a, unf_a, empty_a, r_data_a} !== {4'd1, 1'b1, 1'b0, 8'hA5}) begin
      bad++; $display("FAIL simul_empty got=%0d/%b/%b/%h exp=1/1/0/a5", count_a, unf_a, empty_a, r_data_a); end
  endtask

  task automatic test_clear();
    flush_a();
    for (int i = 0; i < 8; i++) push_a(8'(8'h40 + i));
    push_a(8'hEE);
    for (int i = 0; i < 4; i++) pop_a();
    total++; if ({count_a, ovf_a} !== {4'd4, 1'b1}) begin
      bad++; $display("FAIL clear_setup got=%0d/%b exp=4/1", count_a, ovf_a); end
    clear_a = 1'b1; w_en_a = 1'b1; w_data_a = 8'h77;
    step();
    clear_a = 1'b0; w_en_a = 1'b0;
    total++; if ({count_a, empty_a, ovf_a, unf_a, r_data_a} !== {4'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      bad++; $display("FAIL clear_state got=%0d/%b/%b/%b/%h exp=0/1/0/0/00", count_a, empty_a, ovf_a, unf_a, r_data_a); end
    push_a(8'h55);
    total++; if ({count_a, r_data_a} !== {4'd1, 8'h55}) begin
      bad++; $display("FAIL clear_drop got=%0d/%h exp=1/55", count_a, r_data_a); end
  endtask

  task automatic test_sweep();
    total++; if ({ae_b, af_b, full_b, count_b} !== 6'b100000) begin
      bad++; $display("FAIL sweep_c0 got=%b exp=100000", {ae_b, af_b, full_b, count_b}); end
    for (int i = 1; i <= 4; i++) begin
      push_b(16'(16'h1000 + i));
      total++; if ({ae_b, af_b, full_b, count_b} !== {1'b0, (i >= 3), (i == 4), 3'(i)}) begin
        bad++; $display("FAIL sweep_flags i=%0d got=%b exp=%b", i, {ae_b, af_b, full_b, count_b}, {1'b0, (i >= 3), (i == 4), 3'(i)}); end
    end
    total++; if (r_data_b !== 16'h1001) begin bad++; $display("FAIL sweep_head got=%h exp=1001", r_data_b); end
    pop_b(); pop_b();
    total++; if ({count_b, r_data_b} !== {3'd2, 16'h1003}) begin
      bad++; $display("FAIL sweep_pop got=%0d/%h exp=2/1003", count_b, r_data_b); end
    @(negedge clk);
    n_rst_b = 1'b0;
    #1;
    total++; if ({count_b, empty_b, ae_b, af_b, full_b, r_data_b} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
      bad++; $display("FAIL sweep_reset got=%0d/%b/%b/%b/%b/%h exp=0/1/1/0/0/0000", count_b, empty_b, ae_b, af_b, full_b, r_data_b); end
    #2;
    n_rst_b = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wrap();
    test_back_to_back();
    test_clear();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
